uart_fifo: RTL

- Next-generation memory-mapped UART peripheral on the same simple req/we bus as the existing UART.
- Adds parametrised TX and RX FIFOs, optional even/odd parity, 1 or 2 stop bits, sticky error flags and an interrupt output.
- Frames are LSB-first, 8 data bits.
- Sits on the peripheral bus next to the other perips; tx_pin and rx_pin go to the board pins.

---
 rtl/uart_fifo.sv | 371 +++++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_fifo.sv
// UART peripheral with TX/RX FIFOs, optional parity, 1 or 2 stop bits,
// sticky receive error flags and a level interrupt on a simple req/we bus.

// Byte-wide FIFO; pointers carry one extra wrap bit so full and empty
// are told apart by comparing pointers alone.
module uart_fifo_buf #(
    parameter int unsigned DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic [7:0] wdata,
    input  logic       pop,
    output logic [7:0] rdata,
    output logic       full,
    output logic       empty,
    output logic [8:0] count
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wptr;
    logic [AW:0] rptr;
    logic [AW:0] diff;

    // Storage and pointer update; the caller guarantees push/pop legality.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
            // NOTE: the storage array is reset too, so every flop in the block
            // comes out of reset with a defined value.
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all
            // flops update together from pre-edge values.
            if (push) begin
                mem[wptr[AW-1:0]] <= wdata;
                wptr              <= wptr + (AW+1)'(1);
            end
            if (pop) begin
                rptr <= rptr + (AW+1)'(1);
            end
        end
    end

    assign rdata = mem[rptr[AW-1:0]];
    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign diff  = wptr - rptr;
    assign count = 9'(diff);
endmodule

module uart_fifo #(
    parameter int unsigned TX_DEPTH    = 8,
    parameter int unsigned RX_DEPTH    = 8,
    parameter logic [31:0] DEFAULT_DIV = 32'h1B8
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        tx_pin,
    input  logic        rx_pin,
    output logic        irq_o
);
    localparam logic [7:0] ADDR_CTRL   = 8'h00;
    localparam logic [7:0] ADDR_STATUS = 8'h04;
    localparam logic [7:0] ADDR_BAUD   = 8'h08;
    localparam logic [7:0] ADDR_TXDATA = 8'h0C;
    localparam logic [7:0] ADDR_RXDATA = 8'h10;
    localparam logic [7:0] ADDR_LEVEL  = 8'h14;

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    // Control / configuration
    logic [6:0]  ctrl;
    logic        tx_en, rx_en, par_en, par_odd, stop2, rx_irq_en, tx_irq_en;
    logic [31:0] baud;
    logic [2:0]  flags;      // {frame_err, parity_err, rx_overrun}
    logic [2:0]  flag_set;
    logic [2:0]  flag_clr;

    // Bus decode
    logic [7:0]  addr;
    logic        wr, rd;
    logic        unused_addr;

    // FIFOs
    logic        tx_push, tx_pop, tx_full, tx_empty;
    logic [7:0]  tx_head;
    logic [8:0]  tx_count;
    logic        rx_push, rx_pop, rx_full, rx_empty;
    logic [7:0]  rx_head;
    logic [8:0]  rx_count;

    // TX engine
    state_t      tx_state;
    logic [31:0] tx_cnt;
    logic [2:0]  tx_bit;
    logic [7:0]  tx_shift;
    logic        tx_par;
    logic        tx_stop_two;
    logic        tx_busy;

    // RX engine
    logic        rx_s1, rx_s2, rx_prev;
    state_t      rx_state;
    logic [31:0] rx_cnt;
    logic [2:0]  rx_bit;
    logic [7:0]  rx_shift;
    logic        rx_par;
    logic        rx_fall, stop_hit, par_bad, byte_ok;

    assign tx_en     = ctrl[0];
    assign rx_en     = ctrl[1];
    assign par_en    = ctrl[2];
    assign par_odd   = ctrl[3];
    assign stop2     = ctrl[4];
    assign rx_irq_en = ctrl[5];
    assign tx_irq_en = ctrl[6];

    assign addr        = addr_i[7:0];
    assign wr          = req_i & we_i;
    assign rd          = req_i & ~we_i;
    assign unused_addr = ^addr_i[31:8];

    // A TX write is judged against the pre-edge full flag only.
    assign tx_push = wr && (addr == ADDR_TXDATA) && !tx_full;
    assign tx_pop  = (tx_state == S_IDLE) && tx_en && !tx_empty;
    assign rx_pop  = rd && (addr == ADDR_RXDATA) && !rx_empty;
    assign tx_busy = !tx_empty || (tx_state != S_IDLE);

    uart_fifo_buf #(.DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .push  (tx_push),
        .wdata (data_i[7:0]),
        .pop   (tx_pop),
        .rdata (tx_head),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count)
    );

    uart_fifo_buf #(.DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .push  (rx_push),
        .wdata (rx_shift),
        .pop   (rx_pop),
        .rdata (rx_head),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_count)
    );

    // Read mux: combinational, zero unless a read is being presented.
    always_comb begin
        // NOTE: a default on entry keeps every path assigned, so no latch.
        data_o = '0;
        if (rd) begin
            case (addr)
                ADDR_CTRL:   data_o = {25'b0, ctrl};
                ADDR_STATUS: data_o = {26'b0, flags, tx_full, !rx_empty, tx_busy};
                ADDR_BAUD:   data_o = baud;
                ADDR_RXDATA: data_o = rx_empty ? 32'h0 : {24'b0, rx_head};
                ADDR_LEVEL:  data_o = {7'b0, rx_count, 7'b0, tx_count};
                default:     data_o = '0;
            endcase
        end
    end

    // Configuration registers and sticky flags (a new event beats a clear).
    assign flag_clr = (wr && (addr == ADDR_STATUS)) ? data_i[5:3] : 3'b000;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ctrl  <= '0;
            baud  <= DEFAULT_DIV;
            flags <= '0;
        end else begin
            if (wr && (addr == ADDR_CTRL)) ctrl <= data_i[6:0];
            if (wr && (addr == ADDR_BAUD)) baud <= data_i;
            flags <= (flags & ~flag_clr) | flag_set;
        end
    end

    // TX frame sequencer; tx_pin is a registered output.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tx_state    <= S_IDLE;
            tx_pin      <= 1'b1;
            tx_cnt      <= '0;
            tx_bit      <= '0;
            tx_shift    <= '0;
            tx_par      <= 1'b0;
            tx_stop_two <= 1'b0;
        end else begin
            case (tx_state)
                S_IDLE: begin
                    tx_pin <= 1'b1;
                    if (tx_pop) begin
                        tx_shift <= tx_head;
                        tx_par   <= ^tx_head;
                        tx_cnt   <= baud;
                        tx_pin   <= 1'b0;
                        tx_state <= S_START;
                    end
                end
                S_START: begin
                    if (tx_cnt == 32'd0) begin
                        tx_cnt   <= baud;
                        tx_pin   <= tx_shift[0];
                        tx_bit   <= '0;
                        tx_state <= S_DATA;
                    end else begin
                        tx_cnt <= tx_cnt - 32'd1;
                    end
                end
                S_DATA: begin
                    if (tx_cnt == 32'd0) begin
                        tx_cnt <= baud;
                        if (tx_bit == 3'd7) begin
                            tx_stop_two <= 1'b0;
                            if (par_en) begin
                                tx_pin   <= tx_par ^ par_odd;
                                tx_state <= S_PARITY;
                            end else begin
                                tx_pin   <= 1'b1;
                                tx_state <= S_STOP;
                            end
                        end else begin
                            tx_bit   <= tx_bit + 3'd1;
                            tx_pin   <= tx_shift[1];
                            tx_shift <= {1'b0, tx_shift[7:1]};
                        end
                    end else begin
                        tx_cnt <= tx_cnt - 32'd1;
                    end
                end
                S_PARITY: begin
                    if (tx_cnt == 32'd0) begin
                        tx_cnt   <= baud;
                        tx_pin   <= 1'b1;
                        tx_state <= S_STOP;
                    end else begin
                        tx_cnt <= tx_cnt - 32'd1;
                    end
                end
                S_STOP: begin
                    if (tx_cnt == 32'd0) begin
                        if (stop2 && !tx_stop_two) begin
                            tx_stop_two <= 1'b1;
                            tx_cnt      <= baud;
                        end else begin
                            tx_state <= S_IDLE;
                        end
                    end else begin
                        tx_cnt <= tx_cnt - 32'd1;
                    end
                end
                default: tx_state <= S_IDLE;
            endcase
        end
    end

    // Two-flop synchroniser plus one history flop for start-edge detection.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= rx_pin;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    assign rx_fall  = rx_prev & ~rx_s2;
    assign stop_hit = rx_en && (rx_state == S_STOP) && (rx_cnt == 32'd0);
    assign par_bad  = par_en && (rx_par != (^rx_shift ^ par_odd));
    assign byte_ok  = stop_hit && rx_s2 && !par_bad;
    // A byte may land in a full FIFO when the bus pops in the same cycle.
    assign rx_push  = byte_ok && (!rx_full || rx_pop);
    assign flag_set = {stop_hit && !rx_s2,
                       stop_hit && rx_s2 && par_bad,
                       byte_ok && rx_full && !rx_pop};

    // RX frame sequencer: mid-bit sampling, aborted whenever rx_en drops.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_state <= S_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            rx_par   <= 1'b0;
        end else if (!rx_en) begin
            rx_state <= S_IDLE;
        end else begin
            case (rx_state)
                S_IDLE: begin
                    if (rx_fall) begin
                        rx_cnt   <= baud >> 1;
                        rx_state <= S_START;
                    end
                end
                S_START: begin
                    if (rx_cnt == 32'd0) begin
                        if (rx_s2) begin
                            rx_state <= S_IDLE;
                        end else begin
                            rx_cnt   <= baud;
                            rx_bit   <= '0;
                            rx_state <= S_DATA;
                        end
                    end else begin
                        rx_cnt <= rx_cnt - 32'd1;
                    end
                end
                S_DATA: begin
                    if (rx_cnt == 32'd0) begin
                        rx_shift <= {rx_s2, rx_shift[7:1]};
                        rx_cnt   <= baud;
                        if (rx_bit == 3'd7) begin
                            rx_state <= par_en ? S_PARITY : S_STOP;
                        end else begin
                            rx_bit <= rx_bit + 3'd1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt - 32'd1;
                    end
                end
                S_PARITY: begin
                    if (rx_cnt == 32'd0) begin
                        rx_par   <= rx_s2;
                        rx_cnt   <= baud;
                        rx_state <= S_STOP;
                    end else begin
                        rx_cnt <= rx_cnt - 32'd1;
                    end
                end
                S_STOP: begin
                    if (rx_cnt == 32'd0) begin
                        rx_state <= S_IDLE;
                    end else begin
                        rx_cnt <= rx_cnt - 32'd1;
                    end
                end
                default: rx_state <= S_IDLE;
            endcase
        end
    end

    // Interrupt is registered from flop state only.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            irq_o <= 1'b0;
        end else begin
            irq_o <= (rx_irq_en && !rx_empty) ||
                     (tx_irq_en && !tx_busy) ||
                     (rx_irq_en && (|flags));
        end
    end
endmodule
